// File: rtl/btn_pkg.sv
// Shared constants, types and helpers for the push-button debounce and
// event controller.
package btn_pkg;

    localparam int DEF_TICK_DIV   = 50000;
    localparam int DEF_STABLE_CNT = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Button index width; a single button still gets a 1-bit id.
    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle sample enable every
// TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = btn_pkg::DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounces N_BTN push-buttons and hands out press/release events one at a
// time over a valid/ready port with round-robin arbitration.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int   N_BTN      = 4,
    parameter int   TICK_DIV   = DEF_TICK_DIV,
    parameter int   STABLE_CNT = DEF_STABLE_CNT,
    localparam int  IDW        = idw_of(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic             tick,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDW-1:0]   evt_id,
    output logic             evt_press,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CNT - 1);

    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;
    logic [N_BTN-1:0] level_reg;
    logic [N_BTN-1:0] pend_reg;
    logic [N_BTN-1:0] pend_dir_reg;
    logic [N_BTN-1:0] accept;
    logic [N_BTN-1:0] grant_mask;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   evt_id_reg;
    logic             evt_press_reg;
    logic             ovf_reg;
    state_t           state_reg;
    state_t           state_next;

    logic             grant_any;
    logic             grant_fire;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   rr_ptr_next;
    int               arb_idx;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Per-button stability counter; accept[gi] marks the tick on which the
    // synchronized input has disagreed with the level for STABLE_CNT samples.
    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [7:0] cnt_reg;
            logic       differ;

            assign differ         = sync2_reg[gi] ^ level_reg[gi];
            assign accept[gi]     = tick & differ & (cnt_reg == CNT_LAST);
            assign grant_mask[gi] = grant_fire & (grant_idx == IDW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (tick) begin
                    if (!differ || (cnt_reg == CNT_LAST)) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
            end
        end
    endgenerate

    // Scan downwards so the pending bit closest to rr_ptr is the one kept.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        arb_idx   = 0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            arb_idx = (int'(rr_ptr_reg) + k) % N_BTN;
            if (pend_reg[arb_idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(arb_idx);
            end
        end
    end

    assign grant_fire  = (state_reg == S_IDLE) && grant_any;
    assign rr_ptr_next = (grant_idx == IDW'(N_BTN - 1)) ? '0 : grant_idx + IDW'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (grant_any) state_next = S_HOLD;
            S_HOLD:  if (evt_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg     <= '0;
            sync2_reg     <= '0;
            level_reg     <= '0;
            pend_reg      <= '0;
            pend_dir_reg  <= '0;
            rr_ptr_reg    <= '0;
            evt_id_reg    <= '0;
            evt_press_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            state_reg     <= S_IDLE;
        end else begin
            sync1_reg    <= btn;
            sync2_reg    <= sync1_reg;
            level_reg    <= level_reg ^ accept;
            // A grant consumes the old event even if a new one lands this cycle.
            pend_reg     <= (pend_reg & ~grant_mask) | accept;
            pend_dir_reg <= (pend_dir_reg & ~accept) | (sync2_reg & accept);
            state_reg    <= state_next;

            if (|(accept & pend_reg & ~grant_mask)) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end

            if (grant_fire) begin
                evt_id_reg    <= grant_idx;
                evt_press_reg <= pend_dir_reg[grant_idx];
                rr_ptr_reg    <= rr_ptr_next;
            end
        end
    end

    assign level     = level_reg;
    assign evt_valid = (state_reg == S_HOLD);
    assign evt_id    = evt_id_reg;
    assign evt_press = evt_press_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl with a fast prescaler and short
// stability window.
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [3:0] level;
    logic       tick;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_id;
    logic       evt_press;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    typedef struct {
        int id;
        int press;
    } evt_t;

    evt_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    btn_event_ctrl #(
        .N_BTN      (4),
        .TICK_DIV   (4),
        .STABLE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .level     (level),
        .tick      (tick),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_press (evt_press),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic push_evt(input int id, input int press);
        evt_t e;
        e.id    = id;
        e.press = press;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        btn       = 4'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_lvl(input int i, input int v, output int cyc);
        cyc = 0;
        while (int'(level[i]) != v && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("lvl%0d_to_%0d", i, v), int'(level[i]), v);
    endtask

    task automatic wait_valid();
        int c;
        c = 0;
        while (!evt_valid && c < 60) begin
            @(negedge clk);
            c++;
        end
    endtask

    // Pops the expected event, checks it, optionally stalls, then handshakes.
    task automatic take_event(input int hold_cyc);
        evt_t e;
        bit   stable;
        wait_valid();
        if (!evt_valid) begin
            chk("evt_timeout", 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("evt_unexpected", 1, 0);
            e.id    = -1;
            e.press = -1;
        end else begin
            e = exp_q.pop_front();
        end
        $display("evt id=%0d press=%0d (exp id=%0d press=%0d)", evt_id, evt_press, e.id, e.press);
        chk("evt_id", int'(evt_id), e.id);
        chk("evt_press", int'(evt_press), e.press);
        stable = 1'b1;
        for (int h = 0; h < hold_cyc; h++) begin
            @(negedge clk);
            if (!evt_valid || int'(evt_id) != e.id || int'(evt_press) != e.press) stable = 1'b0;
        end
        if (hold_cyc > 0) chk("evt_stable", int'(stable), 1);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk("evt_drop", int'(evt_valid), 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (evt_valid) seen = 1'b1;
        end
        chk(tag, int'(seen), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_tick;
        int first_tick;
        int last_tick;
        bit gap_ok;

        // 1: reset state and tick cadence
        do_reset();
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_tick", int'(tick), 0);
        n_tick = 0; first_tick = -1; last_tick = -1; gap_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (tick) begin
                n_tick++;
                if (first_tick < 0) first_tick = c;
                if (last_tick >= 0 && c - last_tick != 4) gap_ok = 1'b0;
                last_tick = c;
            end
            if (evt_valid || level != 4'b0 || ovf) gap_ok = 1'b0;
        end
        $display("idle: %0d ticks, first at cycle %0d", n_tick, first_tick);
        chk("tick_count", n_tick, 10);
        chk("tick_first", first_tick, 3);
        chk("tick_gap_idle", int'(gap_ok), 1);

        // 2: single press, latency window, handshake, then release
        btn[2] = 1'b1;
        push_evt(2, 1);
        wait_lvl(2, 1, cyc);
        $display("press btn2: level after %0d clk", cyc);
        chk("lat_window", int'(cyc >= 11 && cyc <= 14), 1);
        chk("lvl_only2", int'(level), 4);
        take_event(0);
        btn[2] = 1'b0;
        push_evt(2, 0);
        wait_lvl(2, 0, cyc);
        take_event(0);

        // 3: glitch of two ticks is rejected
        btn[1] = 1'b1;
        repeat (8) @(negedge clk);
        btn[1] = 1'b0;
        expect_quiet("glitch_evt", 30);
        chk("glitch_lvl", int'(level), 0);

        // 4: simultaneous presses, round-robin order, held event stability
        do_reset();
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        push_evt(0, 1);
        push_evt(3, 1);
        take_event(20);
        take_event(0);
        btn[0] = 1'b0;
        btn[3] = 1'b0;
        push_evt(0, 0);
        push_evt(3, 0);
        take_event(0);
        take_event(0);
        chk("rr_level", int'(level), 0);

        // 5: overwrite of a pending event while another is held
        btn[2] = 1'b1;
        push_evt(2, 1);
        wait_valid();
        chk("ovf_hold_valid", int'(evt_valid), 1);
        btn[1] = 1'b1;
        wait_lvl(1, 1, cyc);
        chk("ovf_before", int'(ovf), 0);
        btn[1] = 1'b0;
        wait_lvl(1, 0, cyc);
        chk("ovf_set", int'(ovf), 1);
        push_evt(1, 0);
        take_event(0);
        take_event(0);
        expect_quiet("ovf_single_evt", 20);
        chk("ovf_sticky", int'(ovf), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(ovf), 0);

        // 6: asynchronous reset in the middle of HOLD
        btn[0] = 1'b1;
        wait_valid();
        chk("t6_hold", int'(evt_valid), 1);
        rst_n = 1'b0;
        btn   = 4'b0;
        #1;
        chk("t6_valid_async", int'(evt_valid), 0);
        chk("t6_level_async", int'(level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        expect_quiet("t6_no_stale", 40);
        chk("t6_level_after", int'(level), 0);
        chk("t6_ovf_after", int'(ovf), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
